pulse_former_handshake: RTL and testbench

// Square-wave generator whose half-period length, in clock cycles, is set by a sample

---
 rtl/pulse_former_pkg.sv | 19 +
 rtl/pulse_former_handshake_phase_counter.sv | 27 ++
 rtl/pulse_former_handshake.sv | 113 +++++++++++
 tb/tb_pulse_former_handshake.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_former_pkg.sv
// Shared widths, reset length and handshake state encoding for the pulse former.
package pulse_former_pkg;

    localparam int unsigned W        = 8;
    localparam int unsigned INIT_LEN = 6;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_EOC = 2'd2,
        DONE     = 2'd3
    } hs_state_t;

    // A zero sample would give an empty phase; clamp it to one cycle.
    function automatic logic [W-1:0] fix_len(input logic [W-1:0] v);
        return (v == '0) ? W'(1) : v;
    endfunction

endpackage

// File: rtl/pulse_former_handshake_phase_counter.sv
// Down-counter timing one half-period; expire is high while the count reads zero.
module phase_counter
    import pulse_former_pkg::*;
(
    input  logic         clock,
    input  logic         reset_,
    input  logic         load,
    input  logic [W-1:0] len,
    output logic         expire
);

    logic [W-1:0] cnt;

    // Reload on each toggle, otherwise count down and park at zero while a phase is stretched.
    always_ff @(posedge clock) begin
        if (reset_) begin
            cnt <= W'(INIT_LEN - 1);
        end else if (load) begin
            cnt <= len - W'(1);
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/pulse_former_handshake.sv
// Square-wave generator whose half-period comes from a sample fetched over soc/eoc.
module pulse_former_handshake
    import pulse_former_pkg::*;
(
    input  logic         clock,
    input  logic         reset_,
    input  logic [W-1:0] numero,
    input  logic         eoc,
    output logic         out,
    output logic         soc
);

    hs_state_t    state;
    hs_state_t    state_next;
    logic [W-1:0] len;
    logic [W-1:0] sample_reg;
    logic [W-1:0] load_len;
    logic         soc_next;
    logic         out_next;
    logic         cnt_load;
    logic         take_sample;
    logic         reload_len;
    logic         expire;

    phase_counter u_phase_counter (
        .clock  (clock),
        .reset_ (reset_),
        .load   (cnt_load),
        .len    (load_len),
        .expire (expire)
    );

    // Handshake state register.
    always_ff @(posedge clock) begin
        if (reset_) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Handshake sequencing and phase toggling; a high phase only ends once the sample is in.
    always_comb begin
        state_next  = state;
        soc_next    = 1'b0;
        take_sample = 1'b0;
        reload_len  = 1'b0;
        out_next    = out;
        cnt_load    = 1'b0;

        case (state)
            IDLE: begin
                if (!out && expire) begin
                    soc_next   = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                // The converter must drop eoc before a new value is accepted.
                if (eoc) begin
                    soc_next = 1'b1;
                end else begin
                    state_next = WAIT_EOC;
                end
            end
            WAIT_EOC: begin
                if (eoc) begin
                    take_sample = 1'b1;
                    state_next  = DONE;
                end
            end
            DONE: begin
                if (out && expire) begin
                    reload_len = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (!out && expire) begin
            out_next = 1'b1;
            cnt_load = 1'b1;
        end
        if (reload_len) begin
            out_next = 1'b0;
            cnt_load = 1'b1;
        end

        // The counter must see the new length on the very edge that installs it.
        load_len = reload_len ? sample_reg : len;
    end

    // Output flops plus the period-length and sample registers.
    always_ff @(posedge clock) begin
        if (reset_) begin
            out        <= 1'b0;
            soc        <= 1'b0;
            len        <= W'(INIT_LEN);
            sample_reg <= W'(INIT_LEN);
        end else begin
            out <= out_next;
            soc <= soc_next;
            if (take_sample) begin
                sample_reg <= fix_len(numero);
            end
            if (reload_len) begin
                len <= sample_reg;
            end
        end
    end

endmodule

// File: tb/tb_pulse_former_handshake.sv
// Randomized bench for pulse_former_handshake with a converter responder and a phase-level model.
module tb_pulse_former_handshake;

    logic       clock;
    logic       reset_;
    logic [7:0] numero;
    logic       eoc;
    logic       out;
    logic       soc;

    int checks = 0;
    int errors = 0;

    pulse_former_handshake dut (
        .clock  (clock),
        .reset_ (reset_),
        .numero (numero),
        .eoc    (eoc),
        .out    (out),
        .soc    (soc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Converter responder: answers soc after short random delays, values from a queue or random.
    int conv_st  = 0;
    int dly      = 0;
    int max_dly  = 1;
    int rnd_max  = 20;
    bit hold_eoc = 1'b0;
    int val_q[$];

    always @(negedge clock) begin
        if (reset_) begin
            conv_st = 0;
            eoc     = 1'b1;
            numero  = 8'($urandom_range(0, 255));
        end else begin
            case (conv_st)
                0: begin
                    numero = 8'($urandom_range(0, 255));
                    if (soc && !hold_eoc) begin
                        dly     = $urandom_range(0, max_dly);
                        conv_st = 1;
                    end
                end
                1: begin
                    numero = 8'($urandom_range(0, 255));
                    if (dly == 0) begin
                        eoc     = 1'b0;
                        dly     = $urandom_range(0, max_dly);
                        conv_st = 2;
                    end else begin
                        dly = dly - 1;
                    end
                end
                default: begin
                    if (dly == 0) begin
                        eoc = 1'b1;
                        if (val_q.size() > 0) numero = 8'(val_q.pop_front());
                        else numero = 8'($urandom_range(0, rnd_max));
                        conv_st = 0;
                    end else begin
                        numero = 8'($urandom_range(0, 255));
                        dly = dly - 1;
                    end
                end
            endcase
        end
    end

    // Phase-level model: age counts edges in the current level, hs tracks handshake progress.
    bit m_valid = 1'b0;
    bit m_out, m_soc;
    int age, cur_len, hs, hs_b, smp;
    bit expd;
    int soc_rises = 0;
    bit soc_prev  = 1'b0;
    int prints    = 0;

    always @(posedge clock) begin
        if (reset_) begin
            m_out = 1'b0; m_soc = 1'b0; age = 0; cur_len = 6; hs = 0; smp = 6;
            m_valid = 1'b1;
        end else if (m_valid) begin
            hs_b = hs;
            expd = (age >= cur_len - 1);
            if (hs_b == 1 && !eoc) begin
                hs = 2; m_soc = 1'b0;
            end else if (hs_b == 2 && eoc) begin
                hs = 3; smp = (numero == 8'd0) ? 1 : int'(numero);
            end
            if (!m_out && expd) begin
                m_out = 1'b1; age = 0; hs = 1; m_soc = 1'b1;
            end else if (m_out && expd && hs_b == 3) begin
                m_out = 1'b0; age = 0; cur_len = smp; hs = 0;
            end else begin
                age = age + 1;
            end
        end
        #1;
        if (m_valid) begin
            checks += 2;
            if (out !== m_out) begin
                errors++;
                if (prints < 20) $display("FAIL out t=%0t got %b expected %b", $time, out, m_out);
                prints++;
            end
            if (soc !== m_soc) begin
                errors++;
                if (prints < 20) $display("FAIL soc t=%0t got %b expected %b", $time, soc, m_soc);
                prints++;
            end
            if (soc === 1'b1 && !soc_prev) soc_rises++;
            soc_prev = (soc === 1'b1);
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    // Count consecutive sampled cycles with out at lvl; a runaway phase is a failure.
    task automatic run_len(input logic lvl, output int n);
        n = 0;
        while (out === lvl && n < 400) begin
            n++;
            @(posedge clock); #1;
        end
        if (n >= 400) begin
            checks++; errors++;
            $display("FAIL phase_timeout level %b got %0d cycles expected under 400", lvl, n);
        end
    endtask

    task automatic wait_high(input bit on_soc, input string name);
        int k = 0;
        while (((on_soc ? soc : out) !== 1'b1) && k < 500) begin
            k++;
            @(posedge clock); #1;
        end
        chk(name, (k < 500) ? 1 : 0, 1);
    endtask

    int n;

    initial begin
        reset_ = 1'b1; eoc = 1'b1; numero = 8'd0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_out", int'(out), 0);
        chk("reset_soc", int'(soc), 0);

        // Chained samples with a quick converter.
        val_q = '{10, 25, 15, 6};
        reset_ = 1'b0;
        run_len(1'b0, n); chk("low_init", n, 6);
        chk("soc_at_rise", int'(soc), 1);
        run_len(1'b1, n); chk("high_init", n, 6);
        run_len(1'b0, n); chk("low10", n, 10);
        run_len(1'b1, n); chk("high10", n, 10);
        run_len(1'b0, n); chk("low25", n, 25);
        run_len(1'b1, n); chk("high25", n, 25);
        run_len(1'b0, n); chk("low15", n, 15);
        run_len(1'b1, n); chk("high15", n, 15);
        chk("soc_pulses", soc_rises, 4);

        // Converter never drops eoc: the high phase must stretch.
        hold_eoc = 1'b1;
        run_len(1'b0, n); chk("low6", n, 6);
        repeat (9) @(posedge clock);
        #1;
        chk("stretch_out", int'(out), 1);
        chk("stretch_soc", int'(soc), 1);
        max_dly = 0;
        val_q.push_back(4);
        val_q.push_back(0);
        hold_eoc = 1'b0;
        run_len(1'b1, n);
        run_len(1'b0, n); chk("low4", n, 4);
        run_len(1'b1, n); chk("high4", n, 4);
        run_len(1'b0, n); chk("low_zero", n, 1);
        run_len(1'b1, n);

        // Random traffic with slower converter and occasional stuck eoc.
        max_dly = 3;
        rnd_max = 12;
        for (int i = 0; i < 1500; i++) begin
            @(posedge clock); #1;
            if ($urandom_range(0, 199) == 0) hold_eoc = !hold_eoc;
        end
        hold_eoc = 1'b0;

        // Reset in the middle of a high phase.
        wait_high(1'b0, "reach_high");
        reset_ = 1'b1;
        @(posedge clock); #1;
        chk("rst_high_out", int'(out), 0);
        chk("rst_high_soc", int'(soc), 0);
        reset_ = 1'b0;
        run_len(1'b0, n); chk("low_after_rst_high", n, 6);

        // Reset while soc is requesting.
        wait_high(1'b1, "reach_req");
        reset_ = 1'b1;
        @(posedge clock); #1;
        chk("rst_req_out", int'(out), 0);
        chk("rst_req_soc", int'(soc), 0);
        reset_ = 1'b0;
        run_len(1'b0, n); chk("low_after_rst_req", n, 6);

        repeat (40) @(posedge clock);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
